// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter that shares the VGA adapter pixel port among NUM_REQ requesters.
// Define PXARB_FILL_EN to build the rectangle fill engine (fill ports are inert otherwise).
module pixel_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_x,
   input  logic [7*NUM_REQ-1:0]   req_y,
   input  logic [3*NUM_REQ-1:0]   req_colour,
   output logic [NUM_REQ-1:0]     gnt,
   input  logic                   fill_start,
   input  logic [7:0]             fill_x0,
   input  logic [7:0]             fill_x1,
   input  logic [6:0]             fill_y0,
   input  logic [6:0]             fill_y1,
   input  logic [2:0]             fill_colour,
   output logic                   fill_busy,
   output logic                   fill_done,
   output logic [7:0]             x_out,
   output logic [6:0]             y_out,
   output logic [2:0]             colour,
   output logic                   plot
);

   localparam int         PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int         IDX_W = PTR_W + 1;
   localparam logic [7:0] X_LIM = 8'(X_MAX);
   localparam logic [6:0] Y_LIM = 7'(Y_MAX);

   typedef enum logic {IDLE, FILL} state_t;

   state_t             state_q, state_d;
   logic               arb_en;
   logic [PTR_W-1:0]   ptr_q, sel;
   logic               found, gnt_ok;
   logic               fill_req, fill_degen, fill_last, fill_go;
   logic               nxt_vld;
   logic [7:0]         nxt_x, pix_x;
   logic [6:0]         nxt_y, pix_y;
   logic [2:0]         nxt_col, pix_col;
   logic               pix_take;

   logic [7:0] rx [NUM_REQ];
   logic [6:0] ry [NUM_REQ];
   logic [2:0] rc [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign rx[g] = req_x[8*g +: 8];
      assign ry[g] = req_y[7*g +: 7];
      assign rc[g] = req_colour[3*g +: 3];
   end

   function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
      return (x <= X_LIM) && (y <= Y_LIM);
   endfunction

   // Arbitration is held off for one cycle after reset release so grants never
   // race the deassertion edge; it also forces gnt low the instant reset asserts.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (!resetn) arb_en <= 1'b0;
      else         arb_en <= 1'b1;
   end

   always_comb begin : p_rr_search
      logic [IDX_W-1:0] idx;
      // NOTE: every combinational output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      idx   = '0;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr_q} + IDX_W'(k);
         if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
         if (!found && req[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            sel   = idx[PTR_W-1:0];
         end
      end
   end

   always_comb begin : p_fsm_next
      state_d = state_q;
      fill_go = 1'b0;
      case (state_q)
         IDLE: begin
            if (fill_req) begin
               fill_go = 1'b1;
               if (!fill_degen) state_d = FILL;
            end
         end
         FILL:    if (fill_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // A fill request owns the output slot of the following cycle, so it wins ties.
   assign gnt_ok = arb_en && (state_q == IDLE) && !fill_go && found;
   assign gnt    = gnt_ok ? (NUM_REQ'(1) << sel) : '0;

`ifdef PXARB_FILL_EN
   logic [7:0] fx0_q, fx1_q, cur_x;
   logic [6:0] fy1_q, cur_y;
   logic [2:0] fcol_q;

   assign fill_req   = fill_start;
   assign fill_degen = (fill_x0 > fill_x1) || (fill_y0 > fill_y1);
   assign fill_last  = (cur_x == fx1_q) && (cur_y == fy1_q);

   // cur_x/cur_y track the fill pixel currently on the output port.
   always_comb begin : p_fill_next
      nxt_vld = 1'b0;
      nxt_x   = cur_x;
      nxt_y   = cur_y;
      nxt_col = fcol_q;
      if ((state_q == IDLE) && fill_go && !fill_degen) begin
         nxt_vld = 1'b1;
         nxt_x   = fill_x0;
         nxt_y   = fill_y0;
         nxt_col = fill_colour;
      end else if ((state_q == FILL) && !fill_last) begin
         nxt_vld = 1'b1;
         if (cur_x == fx1_q) begin
            nxt_x = fx0_q;
            nxt_y = cur_y + 7'd1;
         end else begin
            nxt_x = cur_x + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fx0_q     <= '0;
         fx1_q     <= '0;
         fy1_q     <= '0;
         fcol_q    <= '0;
         cur_x     <= '0;
         cur_y     <= '0;
         fill_busy <= 1'b0;
         fill_done <= 1'b0;
      end else begin
         if (fill_go && !fill_degen) begin
            fx0_q  <= fill_x0;
            fx1_q  <= fill_x1;
            fy1_q  <= fill_y1;
            fcol_q <= fill_colour;
         end
         if (nxt_vld) begin
            cur_x <= nxt_x;
            cur_y <= nxt_y;
         end
         fill_busy <= nxt_vld;
         fill_done <= (fill_go && fill_degen) || ((state_q == FILL) && fill_last);
      end
   end
`else
   logic unused_fill;

   assign fill_req    = 1'b0;
   assign fill_degen  = 1'b0;
   assign fill_last   = 1'b0;
   assign nxt_vld     = 1'b0;
   assign nxt_x       = '0;
   assign nxt_y       = '0;
   assign nxt_col     = '0;
   assign fill_busy   = 1'b0;
   assign fill_done   = 1'b0;
   assign unused_fill = ^{fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_colour};
`endif

   always_comb begin : p_pix_mux
      pix_take = nxt_vld;
      pix_x    = nxt_x;
      pix_y    = nxt_y;
      pix_col  = nxt_col;
      if (!nxt_vld) begin
         pix_take = gnt_ok;
         pix_x    = rx[sel];
         pix_y    = ry[sel];
         pix_col  = rc[sel];
      end
   end

   // Off-screen pixels are consumed but never plotted; the port holds its last value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_q  <= '0;
         x_out  <= '0;
         y_out  <= '0;
         colour <= '0;
         plot   <= 1'b0;
      end else begin
         plot <= 1'b0;
         if (gnt_ok) ptr_q <= (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
         if (pix_take && on_screen(pix_x, pix_y)) begin
            plot   <= 1'b1;
            x_out  <= pix_x;
            y_out  <= pix_y;
            colour <= pix_col;
         end
      end
   end

endmodule
